// File: rtl/branch_hazard_ctrl.sv
// Branch hazard controller for a 5-stage pipeline with branches resolved in ID.
// Optional stall counter enabled by defining BRANCH_STALL_CNT_EN.
module branch_hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_Branch,
  input  logic [4:0]  id_Ra,
  input  logic [4:0]  id_Rb,
  input  logic [4:0]  ex_Rw,
  input  logic        ex_RegWr,
  input  logic        ex_MemtoReg,
  input  logic [4:0]  mem_Rw,
  input  logic        mem_RegWr,
  input  logic        mem_MemtoReg,
  input  logic        branch_taken,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_bubble,
  output logic        ifid_flush,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t state, next_state;
  logic   match_ex, match_mem;
  logic   stall, flush;

  // Register 0 is hard-wired to zero, so writing it never creates a dependency.
  assign match_ex  = ex_RegWr  && (ex_Rw  != 5'd0) && ((ex_Rw  == id_Ra) || (ex_Rw  == id_Rb));
  assign match_mem = mem_RegWr && (mem_Rw != 5'd0) && ((mem_Rw == id_Ra) || (mem_Rw == id_Rb));

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    flush      = 1'b0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (id_Branch) begin
            if (match_ex && ex_MemtoReg) begin
              stall      = 1'b1;
              next_state = HOLD;
            end else if (match_ex || (match_mem && mem_MemtoReg)) begin
              stall = 1'b1;
            end else if (branch_taken) begin
              flush      = 1'b1;
              next_state = FLUSH;
            end
          end
        end
        HOLD: begin
          stall      = 1'b1;
          next_state = IDLE;
        end
        FLUSH:   next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign idex_bubble = stall;
  assign ifid_flush  = flush;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

`ifdef BRANCH_STALL_CNT_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cnt <= 16'd0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

  assign stall_count = stall_cnt;
`else
  assign stall_count = 16'd0;
`endif

endmodule
